// File: rtl/mpu_regs_pkg.sv
// mpu_regs_pkg
// Shared definitions for the MPU-6050 register emulation: register addresses
// of the emulated map and the target-side I2C state encoding (also used by
// the master-side controller when it tracks the target).
package mpu_regs_pkg;

  localparam logic [7:0] REG_SMPLRT_DIV   = 8'h19;
  localparam logic [7:0] REG_GYRO_CFG     = 8'h1B;
  localparam logic [7:0] REG_ACCEL_CFG    = 8'h1C;
  localparam logic [7:0] REG_ACCEL_XOUT_H = 8'h3B;
  localparam logic [7:0] REG_GYRO_ZOUT_L  = 8'h48;
  localparam logic [7:0] REG_PWR_MGMT_1   = 8'h6B;
  localparam logic [7:0] REG_WHO_AM_I     = 8'h75;

  localparam logic [7:0] PWR_MGMT_1_RESET = 8'h40;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_WAIT_STOP
  } tgt_state_t;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync
// Synchronizes the raw scl/sda lines into the clock domain and detects bus
// events from the synchronized levels.
// Ports:
//   clock, reset        system clock, asynchronous active-high reset
//   scl_line, sda_line  raw bus levels
//   sda_sync            synchronized sda level
//   scl_rise, scl_fall  one-cycle pulses on synchronized scl edges
//   start_det, stop_det one-cycle pulses: sda falls / rises while scl high
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic scl_line,
  input  logic sda_line,
  output logic sda_sync,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det
);

  logic [SYNC_STAGES-1:0] scl_pipe;
  logic [SYNC_STAGES-1:0] sda_pipe;
  logic                   scl_prev;
  logic                   sda_prev;
  logic                   scl_now;

  // Idle bus is high on both lines, so reset to 1 to avoid a phantom edge
  // or START right after reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      scl_pipe <= '1;
      sda_pipe <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_pipe <= {scl_pipe[SYNC_STAGES-2:0], scl_line};
      sda_pipe <= {sda_pipe[SYNC_STAGES-2:0], sda_line};
      scl_prev <= scl_pipe[SYNC_STAGES-1];
      sda_prev <= sda_pipe[SYNC_STAGES-1];
    end
  end

  assign scl_now   = scl_pipe[SYNC_STAGES-1];
  assign sda_sync  = sda_pipe[SYNC_STAGES-1];
  assign scl_rise  = scl_now & ~scl_prev;
  assign scl_fall  = ~scl_now & scl_prev;
  // scl must be high on both samples so an scl edge is never mistaken for
  // a START/STOP.
  assign start_det = scl_now & scl_prev & sda_prev & ~sda_sync;
  assign stop_det  = scl_now & scl_prev & ~sda_prev & sda_sync;

endmodule

// File: rtl/mpu_i2c_target.sv
// mpu_i2c_target
// I2C target emulating the MPU-6050 register interface. Sensor samples come
// in on a parallel port and are served big-endian at 0x3B-0x48; host writes
// to the configuration registers are captured and exported.
// Ports:
//   clock, reset         system clock (>= 16x scl), async active-high reset
//   scl, sda             I2C bus; sda is open-drain (drives 0 or 'z only)
//   sample_load          one-cycle pulse latching the sample inputs
//   accel_*/temp/gyro_*  16-bit samples
//   smplrt_div, gyro_config, accel_config, pwr_mgmt_1  config registers
//   wr_strobe/wr_addr/wr_data  pulse + pointer/data of each accepted write
//   busy                 high from START until STOP
module mpu_i2c_target
  import mpu_regs_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR     = 7'h68,
  parameter logic [7:0] WHO_AM_I_VAL = 8'h68,
  parameter int         SYNC_STAGES  = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        scl,
  inout  wire         sda,
  input  logic        sample_load,
  input  logic [15:0] accel_x,
  input  logic [15:0] accel_y,
  input  logic [15:0] accel_z,
  input  logic [15:0] temp,
  input  logic [15:0] gyro_x,
  input  logic [15:0] gyro_y,
  input  logic [15:0] gyro_z,
  output logic [7:0]  smplrt_div,
  output logic [7:0]  gyro_config,
  output logic [7:0]  accel_config,
  output logic [7:0]  pwr_mgmt_1,
  output logic        wr_strobe,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  logic sda_s, scl_rise, scl_fall, start_det, stop_det;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clock     (clock),
    .reset     (reset),
    .scl_line  (scl),
    .sda_line  (sda),
    .sda_sync  (sda_s),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det)
  );

  tgt_state_t  state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [7:0]  ptr;
  logic        rw;
  logic        ack_phase;  // ACK slot: 0 = not yet driven/sampled, 1 = done
  logic        sda_low;
  logic [7:0]  rx_byte;
  logic [7:0]  rd_byte;
  logic [3:0]  rd_off;
  logic [15:0] rd_word;
  logic [15:0] sample_in [7];
  logic [15:0] shadow    [7];
  logic [15:0] hold      [7];
  logic        pending;

  assign sda     = sda_low ? 1'b0 : 1'bz;
  assign busy    = (state != ST_IDLE);
  assign rx_byte = {shift[6:0], sda_s};

  assign sample_in[0] = accel_x;
  assign sample_in[1] = accel_y;
  assign sample_in[2] = accel_z;
  assign sample_in[3] = temp;
  assign sample_in[4] = gyro_x;
  assign sample_in[5] = gyro_y;
  assign sample_in[6] = gyro_z;

  // Read view of the register at the current pointer.
  always_comb begin
    rd_byte = 8'h00;
    rd_off  = 4'(ptr - REG_ACCEL_XOUT_H);
    rd_word = shadow[rd_off[3:1]];
    if (ptr >= REG_ACCEL_XOUT_H && ptr <= REG_GYRO_ZOUT_L) begin
      rd_byte = rd_off[0] ? rd_word[7:0] : rd_word[15:8];
    end else begin
      case (ptr)
        REG_SMPLRT_DIV: rd_byte = smplrt_div;
        REG_GYRO_CFG:   rd_byte = gyro_config;
        REG_ACCEL_CFG:  rd_byte = accel_config;
        REG_PWR_MGMT_1: rd_byte = pwr_mgmt_1;
        REG_WHO_AM_I:   rd_byte = WHO_AM_I_VAL;
        default:        rd_byte = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      ptr          <= '0;
      rw           <= 1'b0;
      ack_phase    <= 1'b0;
      sda_low      <= 1'b0;
      smplrt_div   <= '0;
      gyro_config  <= '0;
      accel_config <= '0;
      pwr_mgmt_1   <= PWR_MGMT_1_RESET;
      wr_strobe    <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
    end else begin
      wr_strobe <= 1'b0;
      if (start_det) begin
        state     <= ST_ADDR;
        bit_cnt   <= '0;
        sda_low   <= 1'b0;
        ack_phase <= 1'b0;
      end else if (stop_det) begin
        state     <= ST_IDLE;
        sda_low   <= 1'b0;
        ack_phase <= 1'b0;
      end else if (scl_rise) begin
        case (state)
          ST_ADDR, ST_REG, ST_WDATA: begin
            shift   <= rx_byte;
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              if (state == ST_ADDR) begin
                rw    <= sda_s;
                state <= (rx_byte[7:1] == DEV_ADDR) ? ST_ADDR_ACK : ST_WAIT_STOP;
              end else if (state == ST_REG) begin
                ptr   <= rx_byte;
                state <= ST_REG_ACK;
              end else begin
                case (ptr)
                  REG_SMPLRT_DIV: smplrt_div   <= rx_byte;
                  REG_GYRO_CFG:   gyro_config  <= rx_byte;
                  REG_ACCEL_CFG:  accel_config <= rx_byte;
                  REG_PWR_MGMT_1: pwr_mgmt_1   <= rx_byte;
                  default: ;
                endcase
                wr_strobe <= 1'b1;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
                ptr       <= ptr + 8'd1;
                state     <= ST_WDATA_ACK;
              end
            end
          end
          ST_RDATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= ST_RDATA_ACK;
          end
          ST_RDATA_ACK: begin
            // Master's ACK bit; sda was released on the preceding fall.
            if (sda_s) begin
              state <= ST_WAIT_STOP;
            end else begin
              ptr       <= ptr + 8'd1;
              ack_phase <= 1'b1;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state)
          // Entered on the 8th rise: first fall starts the ACK drive, the
          // second fall ends it and hands over to the next byte.
          ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: begin
            if (!ack_phase) begin
              sda_low   <= 1'b1;
              ack_phase <= 1'b1;
            end else begin
              sda_low   <= 1'b0;
              ack_phase <= 1'b0;
              bit_cnt   <= '0;
              if (state == ST_ADDR_ACK && rw) begin
                shift   <= rd_byte;
                sda_low <= ~rd_byte[7];
                state   <= ST_RDATA;
              end else begin
                state <= (state == ST_ADDR_ACK) ? ST_REG : ST_WDATA;
              end
            end
          end
          ST_RDATA: begin
            shift   <= {shift[6:0], 1'b0};
            sda_low <= ~shift[6];
          end
          ST_RDATA_ACK: begin
            if (!ack_phase) begin
              sda_low <= 1'b0;
            end else begin
              // Pointer already advanced on the ACK rise.
              shift     <= rd_byte;
              sda_low   <= ~rd_byte[7];
              bit_cnt   <= '0;
              ack_phase <= 1'b0;
              state     <= ST_RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Samples arriving mid-transaction are parked so a burst read never mixes
  // old and new data; the last load wins and lands once the bus is idle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 7; i++) begin
        shadow[i] <= '0;
        hold[i]   <= '0;
      end
      pending <= 1'b0;
    end else if (sample_load && !busy) begin
      shadow  <= sample_in;
      pending <= 1'b0;
    end else if (sample_load) begin
      hold    <= sample_in;
      pending <= 1'b1;
    end else if (pending && !busy) begin
      shadow  <= hold;
      pending <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mpu_i2c_target.sv
// tb_mpu_i2c_target
// Bit-banged I2C master driving mpu_i2c_target with randomized transactions,
// checked against a register-map model of the emulated sensor.
module tb_mpu_i2c_target;

  localparam int Q = 5;  // clocks per quarter scl period (scl = clock/20)

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        scl = 1'b1;
  logic        master_low = 1'b0;
  logic        sample_load = 1'b0;
  logic [15:0] accel_x = '0, accel_y = '0, accel_z = '0, temp = '0;
  logic [15:0] gyro_x = '0, gyro_y = '0, gyro_z = '0;
  logic [7:0]  smplrt_div, gyro_config, accel_config, pwr_mgmt_1;
  logic        wr_strobe, busy;
  logic [7:0]  wr_addr, wr_data;

  wire sda;
  pullup (sda);
  assign sda = master_low ? 1'b0 : 1'bz;

  mpu_i2c_target dut (
    .clock        (clock),
    .reset        (reset),
    .scl          (scl),
    .sda          (sda),
    .sample_load  (sample_load),
    .accel_x      (accel_x),
    .accel_y      (accel_y),
    .accel_z      (accel_z),
    .temp         (temp),
    .gyro_x       (gyro_x),
    .gyro_y       (gyro_y),
    .gyro_z       (gyro_z),
    .smplrt_div   (smplrt_div),
    .gyro_config  (gyro_config),
    .accel_config (accel_config),
    .pwr_mgmt_1   (pwr_mgmt_1),
    .wr_strobe    (wr_strobe),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  m_smplrt, m_gyro, m_accel, m_pwr, m_ptr;
  logic [15:0] m_shadow [7];
  logic [15:0] m_hold   [7];
  bit          m_pending, m_in_txn;
  logic [15:0] strobe_q [$];
  logic [15:0] exp_q    [$];

  task automatic m_reset();
    m_smplrt = 0; m_gyro = 0; m_accel = 0; m_pwr = 8'h40; m_ptr = 0;
    for (int i = 0; i < 7; i++) begin m_shadow[i] = 0; m_hold[i] = 0; end
    m_pending = 0; m_in_txn = 0;
  endtask

  function automatic logic [7:0] m_read(input logic [7:0] a);
    int idx;
    if (a == 8'h19) return m_smplrt;
    if (a == 8'h1B) return m_gyro;
    if (a == 8'h1C) return m_accel;
    if (a == 8'h6B) return m_pwr;
    if (a == 8'h75) return 8'h68;
    if (a >= 8'h3B && a <= 8'h48) begin
      idx = int'(a) - 'h3B;
      return (idx % 2 == 0) ? m_shadow[idx / 2][15:8] : m_shadow[idx / 2][7:0];
    end
    return 8'h00;
  endfunction

  task automatic m_write(input logic [7:0] a, input logic [7:0] d);
    if (a == 8'h19) m_smplrt = d;
    if (a == 8'h1B) m_gyro = d;
    if (a == 8'h1C) m_accel = d;
    if (a == 8'h6B) m_pwr = d;
  endtask

  always @(posedge clock) if (wr_strobe) strobe_q.push_back({wr_addr, wr_data});

  // ---------------- bus master ----------------
  task automatic wait_q();
    repeat (Q) @(negedge clock);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    master_low = ~b; wait_q();
    scl = 1'b1;      wait_q();
    r = sda;         wait_q();
    scl = 1'b0;      wait_q();
  endtask

  task automatic i2c_start();
    master_low = 1'b0; wait_q();
    scl = 1'b1;        wait_q();
    master_low = 1'b1; wait_q();
    scl = 1'b0;        wait_q();
    m_in_txn = 1;
  endtask

  task automatic i2c_stop();
    master_low = 1'b1; wait_q();
    scl = 1'b1;        wait_q();
    master_low = 1'b0; wait_q(); wait_q();
    m_in_txn = 0;
    if (m_pending) begin m_shadow = m_hold; m_pending = 0; end
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], r);
    bit_xfer(1'b1, r);
    ack = ~r;
  endtask

  task automatic read_byte(output logic [7:0] d, input logic give_ack);
    logic r;
    for (int i = 7; i >= 0; i--) begin bit_xfer(1'b1, r); d[i] = r; end
    bit_xfer(~give_ack, r);
  endtask

  logic [15:0] nbuf [7];

  task automatic load_samples();
    @(negedge clock);
    {accel_x, accel_y, accel_z, temp} = {nbuf[0], nbuf[1], nbuf[2], nbuf[3]};
    {gyro_x, gyro_y, gyro_z} = {nbuf[4], nbuf[5], nbuf[6]};
    sample_load = 1'b1;
    @(negedge clock);
    sample_load = 1'b0;
    if (m_in_txn) begin m_hold = nbuf; m_pending = 1; end
    else m_shadow = nbuf;
  endtask

  task automatic chk_cfg();
    chk("smplrt_div", smplrt_div, m_smplrt);
    chk("gyro_config", gyro_config, m_gyro);
    chk("accel_config", accel_config, m_accel);
    chk("pwr_mgmt_1", pwr_mgmt_1, m_pwr);
  endtask

  task automatic chk_strobes();
    logic [15:0] got, exp;
    chk("strobe_cnt", strobe_q.size(), exp_q.size());
    while (strobe_q.size() > 0 && exp_q.size() > 0) begin
      got = strobe_q.pop_front(); exp = exp_q.pop_front();
      chk("strobe_addr_data", got, exp);
    end
    strobe_q.delete(); exp_q.delete();
  endtask

  logic [7:0] wbuf [16];

  task automatic do_write(input logic [6:0] dev, input logic [7:0] ra, input int n);
    logic ack;
    logic hit;
    hit = (dev == 7'h68);
    i2c_start();
    write_byte({dev, 1'b0}, ack);
    chk("addr_ack", ack, hit);
    chk("busy_mid", busy, 1);
    write_byte(ra, ack);
    chk("reg_ack", ack, hit);
    if (hit) m_ptr = ra;
    for (int i = 0; i < n; i++) begin
      write_byte(wbuf[i], ack);
      chk("data_ack", ack, hit);
      if (hit) begin
        exp_q.push_back({m_ptr, wbuf[i]});
        m_write(m_ptr, wbuf[i]);
        m_ptr++;
      end
    end
    i2c_stop();
    chk("busy_after_stop", busy, 0);
    chk_strobes();
    chk_cfg();
    $display("write dev=%02h reg=%02h n=%0d", dev, ra, n);
  endtask

  task automatic do_read(input bit set_ptr, input logic [7:0] ra, input int n, input int load_at);
    logic ack;
    logic [7:0] d;
    i2c_start();
    if (set_ptr) begin
      write_byte(8'hD0, ack); chk("rd_waddr_ack", ack, 1);
      write_byte(ra, ack);    chk("rd_reg_ack", ack, 1);
      m_ptr = ra;
      i2c_start();
    end
    write_byte(8'hD1, ack);
    chk("rd_addr_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      if (i == load_at) load_samples();
      read_byte(d, i != n - 1);
      chk($sformatf("rd_%02h", m_ptr), d, m_read(m_ptr));
      if (i != n - 1) m_ptr++;
    end
    chk("nack_release", sda, 1);
    i2c_stop();
    chk("busy_after_stop", busy, 0);
    $display("read set=%0d reg=%02h n=%0d ptr_now=%02h", set_ptr, ra, n, m_ptr);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ack;
    logic [7:0] picks [8];
    int kind;
    m_reset();
    repeat (4) @(negedge clock);
    chk("rst_pwr", pwr_mgmt_1, 8'h40);
    chk("rst_cfg", {smplrt_div, gyro_config, accel_config}, 0);
    chk("rst_wr", {wr_strobe, wr_addr, wr_data}, 0);
    chk("rst_busy", busy, 0);
    chk("rst_sda", sda, 1);
    reset = 1'b0;
    repeat (4) @(negedge clock);

    // pwr_mgmt_1 wake-up write
    wbuf[0] = 8'h00;
    do_write(7'h68, 8'h6B, 1);

    // WHO_AM_I through a repeated START
    do_read(1, 8'h75, 1, -1);

    // fixed samples, full burst (15th byte at 0x49 is NACKed)
    nbuf = '{16'h1234, 16'h5678, 16'h9ABC, 16'hDEF0, 16'hCAFE, 16'hF00D, 16'hBEEF};
    load_samples();
    do_read(1, 8'h3B, 15, -1);
    do_read(0, 8'h00, 1, -1);

    // wrong device address is ignored
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_write(7'h69, 8'h19, 2);

    // randomized mix of writes / reads incl. pointer wrap
    picks = '{8'h19, 8'h1B, 8'h1C, 8'h6B, 8'hFE, 8'h3A, 8'h47, 8'h74};
    for (int it = 0; it < 12; it++) begin
      kind = $urandom_range(0, 2);
      if (kind == 0) begin
        for (int i = 0; i < 3; i++) wbuf[i] = 8'($urandom);
        do_write(7'h68, ($urandom_range(0, 3) == 0) ? 8'($urandom) : picks[$urandom_range(0, 7)],
                 $urandom_range(1, 3));
      end else if (kind == 1) begin
        do_read(1, picks[$urandom_range(0, 7)], $urandom_range(1, 4), -1);
      end else begin
        do_read(0, 8'h00, $urandom_range(1, 3), -1);
      end
    end

    // new samples mid-burst: old values for this burst, new ones next time
    for (int i = 0; i < 7; i++) nbuf[i] = 16'($urandom);
    do_read(1, 8'h3B, 14, 5);
    do_read(1, 8'h3B, 14, -1);

    // make sure pwr_mgmt_1 differs from its reset value, then reset mid-read
    wbuf[0] = 8'h01;
    do_write(7'h68, 8'h6B, 1);
    i2c_start();
    write_byte(8'hD0, ack);
    write_byte(8'h75, ack);
    i2c_start();
    write_byte(8'hD1, ack);
    chk("rd_bit7_driven_low", sda, 0);
    #1 reset = 1'b1;
    #1 chk("rst_mid_sda", sda, 1);
    chk("rst_mid_pwr", pwr_mgmt_1, 8'h40);
    chk("rst_mid_busy", busy, 0);
    @(negedge clock);
    master_low = 1'b0;
    scl = 1'b1;
    repeat (4) @(negedge clock);
    reset = 1'b0;
    m_reset();
    repeat (4) @(negedge clock);
    wbuf[0] = 8'($urandom);
    do_write(7'h68, 8'h1C, 1);
    do_read(1, 8'h3B, 2, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
